// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the scoreboarded register file.
// The clear FSM state enum lives here so the top and any bench can agree on it.
package regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 32;
   localparam int NRD_DEF    = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending flag per register, set by issue, cleared by write.
// The clear sequence (wipe) overrides everything; an issue beats a same-cycle write.
module regfile_scoreboard #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                set_en,
   input  logic [ADDR_W-1:0]   set_addr,
   input  logic [1:0]          clr_en,
   input  logic [2*ADDR_W-1:0] clr_addr,
   input  logic                wipe_en,
   input  logic [ADDR_W-1:0]   wipe_addr,
   output logic [DEPTH-1:0]    busy
);

   // Register 0 is hardwired zero, so its busy bit never sets.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy[0] <= 1'b0;
         for (int i = 1; i < DEPTH; i++) begin
            if (wipe_en && wipe_addr == ADDR_W'(i)) begin
               busy[i] <= 1'b0;
            end else if (set_en && set_addr == ADDR_W'(i)) begin
               busy[i] <= 1'b1;
            end else if ((clr_en[0] && clr_addr[0 +: ADDR_W] == ADDR_W'(i)) ||
                         (clr_en[1] && clr_addr[ADDR_W +: ADDR_W] == ADDR_W'(i))) begin
               busy[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with issue scoreboard and a sequential clear FSM.
// Optional build macro REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int DEPTH  = DEPTH_DEF,
   parameter  int NRD    = NRD_DEF,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic [NRD-1:0]        rd_busy,
   input  logic [1:0]            wr_en,
   input  logic [2*ADDR_W-1:0]   wr_addr,
   input  logic [2*DATA_W-1:0]   wr_data,
   input  logic                  iss_valid,
   input  logic [ADDR_W-1:0]     iss_addr,
   input  logic                  clr_req,
   output logic                  clr_busy,
   output logic                  clr_done
);

   clr_state_t        state;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy_vec;

   logic [ADDR_W-1:0] wa0, wa1;
   logic [DATA_W-1:0] wd0, wd1;
   logic              idle;
   logic [1:0]        wr_ok;

   assign wa0   = wr_addr[0 +: ADDR_W];
   assign wa1   = wr_addr[ADDR_W +: ADDR_W];
   assign wd0   = wr_data[0 +: DATA_W];
   assign wd1   = wr_data[DATA_W +: DATA_W];
   assign idle  = (state == IDLE);
   assign wr_ok = wr_en & {2{idle}};

   assign clr_busy = (state == CLEAR);

   // Clear FSM walks the counter 0..DEPTH-1 and stops there rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         clr_done <= 1'b0;
      end else begin
         clr_done <= 1'b0;
         case (state)
            IDLE: begin
               if (clr_req) begin
                  state <= CLEAR;
                  cnt   <= '0;
               end
            end
            CLEAR: begin
               if (cnt == ADDR_W'(DEPTH - 1)) begin
                  state    <= IDLE;
                  cnt      <= '0;
                  clr_done <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Port 1 is assigned last so it wins a same-address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (state == CLEAR) begin
         regs[cnt] <= '0;
      end else begin
         if (wr_en[0] && wa0 != '0) begin
            regs[wa0] <= wd0;
         end
         if (wr_en[1] && wa1 != '0) begin
            regs[wa1] <= wd1;
         end
      end
   end

   regfile_scoreboard #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .set_en    (iss_valid && idle),
      .set_addr  (iss_addr),
      .clr_en    (wr_ok),
      .clr_addr  (wr_addr),
      .wipe_en   (clr_busy),
      .wipe_addr (cnt),
      .busy      (busy_vec)
   );

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rdat;
      logic              rbusy;

      assign ra = rd_addr[k*ADDR_W +: ADDR_W];

      always_comb begin
         rdat  = '0;
         rbusy = 1'b0;
         if (ra != '0) begin
            rdat  = regs[ra];
            rbusy = busy_vec[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok[1] && wa1 == ra) begin
               rdat  = wd1;
               rbusy = 1'b0;
            end else if (wr_ok[0] && wa0 == ra) begin
               rdat  = wd0;
               rbusy = 1'b0;
            end
`endif
         end
      end

      assign rd_data[k*DATA_W +: DATA_W] = rdat;
      assign rd_busy[k]                  = rbusy;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb at default sizing (32 x 32-bit, 2 read ports).
// Expectations for same-cycle write/read follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_sb;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 32;
   localparam int NRD    = 2;
   localparam int ADDR_W = 5;

   logic                  clk;
   logic                  rst;
   logic [NRD*ADDR_W-1:0] rd_addr;
   logic [NRD*DATA_W-1:0] rd_data;
   logic [NRD-1:0]        rd_busy;
   logic [1:0]            wr_en;
   logic [2*ADDR_W-1:0]   wr_addr;
   logic [2*DATA_W-1:0]   wr_data;
   logic                  iss_valid;
   logic [ADDR_W-1:0]     iss_addr;
   logic                  clr_req;
   logic                  clr_busy;
   logic                  clr_done;

   int vectors;
   int miscompares;

   regfile_sb #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .NRD    (NRD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .clr_req   (clr_req),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en     = 2'b00;
      iss_valid = 1'b0;
      clr_req   = 1'b0;
   endtask

   task automatic set_rd(input int k, input logic [ADDR_W-1:0] a);
      rd_addr[k*ADDR_W +: ADDR_W] = a;
   endtask

   task automatic set_wr(input int p, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wr_en[p]                    = 1'b1;
      wr_addr[p*ADDR_W +: ADDR_W] = a;
      wr_data[p*DATA_W +: DATA_W] = d;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      rd_addr   = '0;
      wr_addr   = '0;
      wr_data   = '0;
      iss_addr  = '0;
      idle_inputs();
      #2;
      vectors++;
      if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_ctrl: got busy=%b done=%b, expected 0 0", clr_busy, clr_done);
      end
      set_rd(0, 5);
      #1;
      vectors++;
      if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_r5: got %h busy %b, expected 0 busy 0", rd_data[31:0], rd_busy[0]);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write_read();
      set_wr(0, 5, 32'hDEADBEEF);
      tick();
      idle_inputs();
      set_rd(0, 5);
      set_rd(1, 5);
      #1;
      vectors++;
      if (rd_data[31:0] !== 32'hDEADBEEF || rd_data[63:32] !== 32'hDEADBEEF) begin
         miscompares++;
         $display("[TB] FAIL write_r5: got %h/%h, expected deadbeef", rd_data[31:0], rd_data[63:32]);
      end
   endtask

   task automatic test_r0();
      set_wr(0, 0, 32'h1234);
      iss_valid = 1'b1;
      iss_addr  = 0;
      tick();
      idle_inputs();
      set_rd(0, 0);
      #1;
      vectors++;
      if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL r0_zero: got %h busy %b, expected 0 busy 0", rd_data[31:0], rd_busy[0]);
      end
   endtask

   task automatic test_same_addr();
      set_wr(0, 7, 32'h11);
      set_wr(1, 7, 32'h22);
      tick();
      idle_inputs();
      set_rd(1, 7);
      #1;
      vectors++;
      if (rd_data[63:32] !== 32'h22) begin
         miscompares++;
         $display("[TB] FAIL same_addr_r7: got %h, expected 22", rd_data[63:32]);
      end
   endtask

   task automatic test_busy();
      iss_valid = 1'b1;
      iss_addr  = 3;
      tick();
      idle_inputs();
      set_rd(1, 3);
      #1;
      vectors++;
      if (rd_busy[1] !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL busy_issue_r3: got %b, expected 1", rd_busy[1]);
      end
      set_wr(0, 3, 32'h33);
      iss_valid = 1'b1;
      iss_addr  = 3;
      tick();
      idle_inputs();
      #1;
      vectors++;
      if (rd_busy[1] !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL busy_set_wins_r3: got %b, expected 1", rd_busy[1]);
      end
      set_wr(1, 3, 32'h44);
      tick();
      idle_inputs();
      #1;
      vectors++;
      if (rd_busy[1] !== 1'b0 || rd_data[63:32] !== 32'h44) begin
         miscompares++;
         $display("[TB] FAIL busy_write_clears_r3: got busy %b data %h, expected 0 44", rd_busy[1], rd_data[63:32]);
      end
   endtask

   task automatic test_bypass();
      logic [DATA_W-1:0] exp_data;
      logic              exp_busy;
      set_wr(0, 9, 32'h11111111);
      iss_valid = 1'b1;
      iss_addr  = 9;
      tick();
      idle_inputs();
      set_wr(0, 9, 32'h0F0F0F0F);
      set_wr(1, 9, 32'hA5A5A5A5);
      set_rd(0, 9);
      #1;
`ifdef REGFILE_BYPASS_EN
      exp_data = 32'hA5A5A5A5;
      exp_busy = 1'b0;
`else
      exp_data = 32'h11111111;
      exp_busy = 1'b1;
`endif
      vectors++;
      if (rd_data[31:0] !== exp_data || rd_busy[0] !== exp_busy) begin
         miscompares++;
         $display("[TB] FAIL same_cycle_r9: got %h busy %b, expected %h busy %b", rd_data[31:0], rd_busy[0], exp_data, exp_busy);
      end
      tick();
      idle_inputs();
      #1;
      vectors++;
      if (rd_data[31:0] !== 32'hA5A5A5A5 || rd_busy[0] !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL after_write_r9: got %h busy %b, expected a5a5a5a5 busy 0", rd_data[31:0], rd_busy[0]);
      end
   endtask

   task automatic test_clear();
      int busy_cnt;
      int done_cnt;
      for (int i = 1; i < DEPTH; i++) begin
         set_wr(0, ADDR_W'(i), 32'h10000000 + i);
         tick();
         idle_inputs();
      end
      iss_valid = 1'b1;
      iss_addr  = 10;
      tick();
      idle_inputs();
      busy_cnt = 0;
      done_cnt = 0;
      clr_req  = 1'b1;
      tick();
      clr_req = 1'b0;
      set_rd(0, 31);
      #1;
      vectors++;
      if (rd_data[31:0] !== 32'h1000001F) begin
         miscompares++;
         $display("[TB] FAIL read_during_clear_r31: got %h, expected 1000001f", rd_data[31:0]);
      end
      // Hammer writes, issues and further clear requests while the sweep runs.
      for (int c = 0; c < DEPTH + 4; c++) begin
         if (clr_busy === 1'b1) busy_cnt++;
         if (clr_done === 1'b1) done_cnt++;
         if (clr_busy === 1'b1) begin
            set_wr(0, 1, 32'hFFFFFFFF);
            set_wr(1, 2, 32'hEEEEEEEE);
            iss_valid = 1'b1;
            iss_addr  = 3;
            clr_req   = 1'b1;
         end else begin
            idle_inputs();
         end
         tick();
      end
      idle_inputs();
      vectors++;
      if (busy_cnt != DEPTH) begin
         miscompares++;
         $display("[TB] FAIL clr_busy_cycles: got %0d, expected %0d", busy_cnt, DEPTH);
      end
      vectors++;
      if (done_cnt != 1) begin
         miscompares++;
         $display("[TB] FAIL clr_done_pulses: got %0d, expected 1", done_cnt);
      end
      for (int a = 0; a < DEPTH; a++) begin
         set_rd(0, ADDR_W'(a));
         #1;
         vectors++;
         if (rd_data[31:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL cleared_r%0d: got %h busy %b, expected 0 busy 0", a, rd_data[31:0], rd_busy[0]);
         end
      end
   endtask

   task automatic test_reset_abort();
      int done_cnt;
      set_wr(0, 6, 32'h66);
      tick();
      idle_inputs();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      repeat (4) tick();
      vectors++;
      if (clr_busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL abort_in_clear: got busy %b, expected 1", clr_busy);
      end
      #1;
      rst = 1'b1;
      set_rd(0, 6);
      #1;
      vectors++;
      if (clr_busy !== 1'b0 || clr_done !== 1'b0 || rd_data[31:0] !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL abort_async: got busy %b done %b r6 %h, expected 0 0 0", clr_busy, clr_done, rd_data[31:0]);
      end
      @(negedge clk);
      rst      = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < DEPTH + 8; c++) begin
         tick();
         if (clr_done !== 1'b0 || clr_busy !== 1'b0) done_cnt++;
      end
      vectors++;
      if (done_cnt != 0) begin
         miscompares++;
         $display("[TB] FAIL abort_no_done: got %0d active cycles, expected 0", done_cnt);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_write_read();
      test_r0();
      test_same_addr();
      test_busy();
      test_bypass();
      test_clear();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
